// File: rtl/cordic_mult.sv
// Iterative signed-digit CORDIC multiplier (linear rotation mode): product = x * z, no multiplier.
// Define CORDIC_MULT_EARLY_EN to finish as soon as the residual z reaches zero.
module cordic_mult #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cordic_mult_en,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  output logic [2*W-1:0]   product,
  output logic             cordic_mult_flag,
  output logic             busy
);

  localparam int YW = 2*W + 2;
  localparam int ZW = W + 2;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(W - 1);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [ZW-1:0] Z_ONE      = {{(ZW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   count_r;
  logic [W-1:0]    x_r;
  logic [ZW-1:0]   z_r;
  logic [YW-1:0]   y_r;
  logic            load_s;
  logic            iter_s;
  logic            done_s;
  logic            z_zero_s;
  logic            z_neg_s;
  logic [YW-1:0]   x_step_s;
  logic [ZW-1:0]   z_step_s;

  // x zero-extended to the accumulator width, then weighted by 2^k
  function automatic logic [YW-1:0] scale_x(input logic [W-1:0] x, input logic [CW-1:0] k);
    logic [YW-1:0] ext;
    ext = {{(YW-W){1'b0}}, x};
    return ext << k;
  endfunction

  assign z_zero_s = (z_r == {ZW{1'b0}});
  assign z_neg_s  = z_r[ZW-1];
  assign x_step_s = scale_x(x_r, count_r);
  assign z_step_s = Z_ONE << count_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cordic_mult_en) state_s = RUN;
        else                state_s = IDLE;
      end
      RUN: begin
`ifdef CORDIC_MULT_EARLY_EN
        if (z_zero_s)                  state_s = IDLE;
        else if (count_r == COUNT_ZERO) state_s = DONE;
        else                           state_s = RUN;
`else
        if (count_r == COUNT_ZERO) state_s = DONE;
        else                       state_s = RUN;
`endif
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    load_s = 1'b0;
    iter_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: load_s = cordic_mult_en;
      RUN: begin
        iter_s = 1'b1;
`ifdef CORDIC_MULT_EARLY_EN
        done_s = z_zero_s;
`else
        done_s = 1'b0;
`endif
      end
      DONE:    done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Operand load and one signed-digit step per cycle; z==0 leaves y and z untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r     <= {W{1'b0}};
      z_r     <= {ZW{1'b0}};
      y_r     <= {YW{1'b0}};
      count_r <= COUNT_MAX;
    end else if (load_s) begin
      x_r     <= multiplicand;
      z_r     <= {{2{multiplier[W-1]}}, multiplier};
      y_r     <= {YW{1'b0}};
      count_r <= COUNT_MAX;
    end else if (iter_s) begin
      if (z_zero_s) begin
        y_r <= y_r;
        z_r <= z_r;
      end else if (z_neg_s) begin
        y_r <= y_r - x_step_s;
        z_r <= z_r + z_step_s;
      end else begin
        y_r <= y_r + x_step_s;
        z_r <= z_r - z_step_s;
      end
      if (count_r != COUNT_ZERO) count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
      else                       count_r <= count_r;
    end else begin
      count_r <= count_r;
    end
  end

  // Registered outputs; busy follows the next state so it falls with the flag rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product          <= {(2*W){1'b0}};
      cordic_mult_flag <= 1'b0;
      busy             <= 1'b0;
    end else begin
      if (done_s) product <= y_r[2*W-1:0];
      else        product <= product;
      cordic_mult_flag <= done_s;
      busy             <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_cordic_mult.sv
// Directed self-checking bench for cordic_mult (W=16); CORDIC_MULT_EARLY_EN adds early-exit checks.
module tb_cordic_mult;

  logic        clk;
  logic        rst;
  logic        cordic_mult_en;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;
  logic        cordic_mult_flag;
  logic        busy;

  int vectors;
  int miscompares;

  cordic_mult #(.W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .cordic_mult_en   (cordic_mult_en),
    .multiplicand     (multiplicand),
    .multiplier       (multiplier),
    .product          (product),
    .cordic_mult_flag (cordic_mult_flag),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Early exit fires one edge after the step that clears the lowest set bit of z
  function automatic int exp_lat(input logic [15:0] m);
`ifdef CORDIC_MULT_EARLY_EN
    int tz;
    tz = 0;
    while (tz < 16 && m[tz] == 1'b0) tz++;
    return 17 - tz;
`else
    return 17;
`endif
  endfunction

  // Launch one operation and report latency (0 = timeout), result and busy behaviour
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [31:0] prod, output bit busy_ok);
    @(negedge clk);
    multiplicand   = a;
    multiplier     = b;
    cordic_mult_en = 1'b1;
    @(posedge clk); #1;
    cordic_mult_en = 1'b0;
    busy_ok = (busy === 1'b1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cordic_mult_flag === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (lat != 0 && busy !== 1'b0) busy_ok = 1'b0;
    prod = product;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cordic_mult_en = 1'b0;
    multiplicand = 16'd0;
    multiplier = 16'd0;
    #12;
    vectors++;
    if (product !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_product: got %h expected %h", product, 32'd0);
    end
    vectors++;
    if (cordic_mult_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flag: got %b expected 0", cordic_mult_flag);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] prod;
    bit busy_ok;
    do_op(16'd1234, -16'sd567, lat, prod, busy_ok);
    vectors++;
    if (prod !== 32'hFFF552E2) begin   // -699678
      miscompares++;
      $display("FAIL basic_product: got %h expected %h", prod, 32'hFFF552E2);
    end
    vectors++;
    if (lat != 17) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 17", lat);
    end
    vectors++;
    if (!busy_ok) begin
      miscompares++;
      $display("FAIL basic_busy: busy profile wrong, final busy %b expected 0", busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (cordic_mult_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_flag_width: got %b expected 0", cordic_mult_flag);
    end
  endtask

  task automatic test_extremes;
    logic [15:0] av [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] bv [4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF};
    // -2147450880, 2147385345, 0, -1
    logic [31:0] ev [4] = '{32'h80008000, 32'h7FFE8001, 32'h00000000, 32'hFFFFFFFF};
    int lat;
    logic [31:0] prod;
    bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], lat, prod, busy_ok);
      vectors++;
      if (prod !== ev[i]) begin
        miscompares++;
        $display("FAIL extreme_%0d_product: got %h expected %h", i, prod, ev[i]);
      end
      vectors++;
      if (lat != exp_lat(bv[i])) begin
        miscompares++;
        $display("FAIL extreme_%0d_latency: got %0d expected %0d", i, lat, exp_lat(bv[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    int n1;
    int n2;
    logic [31:0] p1;
    logic [31:0] p2;
    @(negedge clk);
    multiplicand = 16'd11;
    multiplier = 16'd13;
    cordic_mult_en = 1'b1;
    @(posedge clk); #1;
    multiplicand = 16'd21;
    multiplier = -16'sd5;
    n1 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cordic_mult_flag === 1'b1) begin
        n1 = n;
        break;
      end
    end
    p1 = product;
    n2 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cordic_mult_flag === 1'b1) begin
        n2 = n;
        break;
      end
    end
    p2 = product;
    cordic_mult_en = 1'b0;
    vectors++;
    if (n1 != 17 || p1 !== 32'd143) begin
      miscompares++;
      $display("FAIL b2b_first: got lat %0d prod %h expected lat 17 prod %h", n1, p1, 32'd143);
    end
    vectors++;
    if (n2 != 18 || p2 !== 32'hFFFFFF97) begin   // -105
      miscompares++;
      $display("FAIL b2b_second: got lat %0d prod %h expected lat 18 prod %h", n2, p2, 32'hFFFFFF97);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_change;
    int lat;
    @(negedge clk);
    multiplicand = 16'd100;
    multiplier = -16'sd3;
    cordic_mult_en = 1'b1;
    @(posedge clk); #1;
    cordic_mult_en = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        multiplicand = 16'd999;
        multiplier = 16'd12345;
        cordic_mult_en = 1'b1;
      end else begin
        cordic_mult_en = 1'b0;
      end
      @(posedge clk); #1;
      if (cordic_mult_flag === 1'b1) begin
        lat = n;
        break;
      end
    end
    cordic_mult_en = 1'b0;
    vectors++;
    if (product !== 32'hFFFFFED4 || lat != 17) begin   // -300
      miscompares++;
      $display("FAIL mid_change: got lat %0d prod %h expected lat 17 prod %h", lat, product, 32'hFFFFFED4);
    end
  endtask

  task automatic test_reset_mid;
    bit flag_seen;
    int lat;
    logic [31:0] prod;
    bit busy_ok;
    @(negedge clk);
    multiplicand = 16'd500;
    multiplier = 16'd77;
    cordic_mult_en = 1'b1;
    @(posedge clk); #1;
    cordic_mult_en = 1'b0;
    for (int n = 1; n <= 8; n++) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (product !== 32'd0 || busy !== 1'b0 || cordic_mult_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got prod %h busy %b flag %b expected 0/0/0", product, busy, cordic_mult_flag);
    end
    flag_seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (cordic_mult_flag !== 1'b0) flag_seen = 1'b1;
    end
    vectors++;
    if (flag_seen) begin
      miscompares++;
      $display("FAIL reset_mid_no_flag: got flag pulse expected none");
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(16'd7, 16'd9, lat, prod, busy_ok);
    vectors++;
    if (prod !== 32'd63 || lat != 17) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got lat %0d prod %h expected lat 17 prod %h", lat, prod, 32'd63);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [15:0] b;
    longint p;
    logic [31:0] exp_p;
    int lat;
    logic [31:0] prod;
    bit busy_ok;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) b[3:0] = 4'b0000;
      p = longint'(a) * longint'($signed(b));
      exp_p = p[31:0];
      do_op(a, b, lat, prod, busy_ok);
      vectors++;
      if (prod !== exp_p || lat != exp_lat(b)) begin
        miscompares++;
        $display("FAIL random_%0d: %0d*%0d got lat %0d prod %h expected lat %0d prod %h",
                 i, a, $signed(b), lat, prod, exp_lat(b), exp_p);
      end
    end
  endtask

`ifdef CORDIC_MULT_EARLY_EN
  task automatic test_early;
    logic [15:0] av [3] = '{16'd1000, 16'd3, 16'd5};
    logic [15:0] bv [3] = '{16'd0, 16'd8, 16'hFFFF};
    logic [31:0] ev [3] = '{32'd0, 32'd24, 32'hFFFFFFFB};
    int          lv [3] = '{1, 14, 17};
    int lat;
    logic [31:0] prod;
    bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], lat, prod, busy_ok);
      vectors++;
      if (prod !== ev[i] || lat != lv[i] || !busy_ok) begin
        miscompares++;
        $display("FAIL early_%0d: got lat %0d prod %h busy_ok %0d expected lat %0d prod %h",
                 i, lat, prod, busy_ok, lv[i], ev[i]);
      end
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_basic;
    test_extremes;
    test_back_to_back;
    test_mid_change;
    test_reset_mid;
    test_random;
`ifdef CORDIC_MULT_EARLY_EN
    test_early;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
